bbox_pixel_scanner: RTL

Walks an axis-aligned bounding box in raster order, emitting one (x, y) pixel coordinate per accepted handshake. It sits directly upstream of the rasterizer's per-pixel stages and replaces ad-hoc min/max/reset sequencing with a single valid/ready stream. Each box is accepted once and fully drained, with backpressure, before the next box is taken.

---
 rtl/bbox_pixel_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bbox_pixel_scanner.sv
// bbox_pixel_scanner: walks an axis-aligned bounding box in raster order and
// emits one (x, y) coordinate per accepted pixel handshake. A box is taken
// only when the scanner is idle. It is then fully drained, or aborted, before
// the next box is taken.
module bbox_pixel_scanner #(
    parameter int HRES = 320,
    parameter int VRES = 180,
    localparam int XW = $clog2(HRES),
    localparam int YW = $clog2(VRES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          bbox_valid_in,
    output logic          bbox_ready_out,
    input  logic [XW-1:0] x_min_in,
    input  logic [XW-1:0] x_max_in,
    input  logic [YW-1:0] y_min_in,
    input  logic [YW-1:0] y_max_in,
    input  logic          abort_in,
    output logic          px_valid_out,
    input  logic          px_ready_in,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          last_out,
    output logic          done_out
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [XW-1:0] X_LIM = XW'(HRES - 1);
    localparam logic [YW-1:0] Y_LIM = YW'(VRES - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x_min_q, x_min_d;
    logic [XW-1:0] x_max_q, x_max_d;
    logic [YW-1:0] y_max_q, y_max_d;
    logic          done_q, done_d;

    logic [XW-1:0] x_max_clamp;
    logic [YW-1:0] y_max_clamp;
    logic          box_empty;
    logic          x_at_end;
    logic          y_at_end;

    // Clamp the offered box to the screen and flag boxes that contain no pixels
    always_comb begin
        x_max_clamp = (x_max_in > X_LIM) ? X_LIM : x_max_in;
        y_max_clamp = (y_max_in > Y_LIM) ? Y_LIM : y_max_in;
        box_empty   = (x_min_in > x_max_clamp) || (y_min_in > y_max_clamp);
    end

    // The scan position never passes the latched max, so plain equality ends a row or the box
    always_comb begin
        x_at_end = (x_q == x_max_q);
        y_at_end = (y_q == y_max_q);
    end

    // Next-state logic: box accept, raster advance, abort and done pulse
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_max_d = y_max_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // An empty box is consumed here without ever entering SCAN
                if (bbox_valid_in && !box_empty) begin
                    state_d = SCAN;
                    x_d     = x_min_in;
                    y_d     = y_min_in;
                    x_min_d = x_min_in;
                    x_max_d = x_max_clamp;
                    y_max_d = y_max_clamp;
                end
            end
            SCAN: begin
                // Abort wins over a handshake in the same cycle; that pixel is dropped
                if (abort_in) begin
                    state_d = IDLE;
                end else if (px_ready_in) begin
                    if (!x_at_end) begin
                        x_d = x_q + XW'(1);
                    end else if (!y_at_end) begin
                        x_d = x_min_q;
                        y_d = y_q + YW'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so outputs drop without a clock
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_max_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_max_q <= y_max_d;
            done_q  <= done_d;
        end
    end

    // Outputs are pure decodes of registered state
    always_comb begin
        bbox_ready_out = (state_q == IDLE);
        px_valid_out   = (state_q == SCAN);
        x_out          = x_q;
        y_out          = y_q;
        last_out       = x_at_end && y_at_end && (state_q == SCAN);
        done_out       = done_q;
    end

endmodule
